traffic_scheduler: RTL and testbench
====================================

TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, the car x restart position in pixels.
REQ-002 SHALL have parameter CAR_WIDTH, default 32, the car width; x at or below it means off-screen left.
REQ-003 SHALL have parameter LANE_SPACING, default 160, the reset stagger between lanes in pixels.
REQ-004 SHALL use one clock and a synchronous, active-high reset, both listed first in the port list.
REQ-005 clk  input  1  system clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  level; moves IDLE to WAIT.
REQ-008 pause  input  1  level; requests freeze of all lanes.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame.
REQ-010 level  input  2  difficulty 0..3, sampled at each lane's sweep slot.
REQ-011 lane_x  output  40  packed car x, lane i at bits [10*i+9:10*i].
REQ-012 state  output  2  IDLE=0, WAIT=1, SWEEP=2, PAUSED=3.
REQ-013 update_done  output  1  one-cycle pulse after a sweep completes.
REQ-014 overrun  output  1  sticky flag; frame_tick arrived while not in WAIT, RUN-side states only.

Function
REQ-015 SHALL sequence 4 lanes through one shared decrement/wrap datapath, one lane per cycle.
REQ-016 IDLE: lanes frozen; start=1 -> WAIT next cycle; frame_tick ignored, overrun unaffected.
REQ-017 WAIT: pause=1 -> PAUSED next cycle (takes priority over frame_tick); else frame_tick=1 -> SWEEP with lane index 0.
REQ-018 SWEEP: 4 cycles, index 0..3; lane idx updated at the end of each cycle; after index 3 -> WAIT, or -> PAUSED if pause=1 in that cycle.
REQ-019 update_done SHALL be 1 for exactly the cycle after the index-3 cycle; tick in cycle t -> update_done in cycle t+5.
REQ-020 PAUSED: lanes and divider counters frozen; pause=0 -> WAIT next cycle; frame_tick ignored, not counted as overrun.
REQ-021 pause asserted mid-SWEEP SHALL NOT abort the sweep; all 4 lanes are processed first.
REQ-022 Per-lane period p_i = max(1, (4-i) - level): lane0 4 frames, lane3 1 frame at level 0.
REQ-023 Per-lane 2-bit divider c_i at its slot: if c_i >= p_i-1 then c_i<=0 and lane moves, else c_i<=c_i+1.
REQ-024 Move: if x > CAR_WIDTH then x<=x-1, else x<=SCREEN_WIDTH (wrap in the same slot, no extra cycle).
REQ-025 A level change with c_i above the new p_i-1 SHALL move the lane at its next slot and clear c_i (>= compare).
REQ-026 frame_tick in SWEEP SHALL be dropped and set overrun; overrun clears only on reset.
REQ-027 start while not in IDLE SHALL be ignored; there is no return to IDLE except reset.
REQ-028 All arithmetic 10-bit unsigned; x never below CAR_WIDTH and never above SCREEN_WIDTH.

Reset
REQ-029 reset SHALL override all inputs in the cycle sampled, including mid-SWEEP.
REQ-030 After reset: state=IDLE, lane index 0, all c_i=0, update_done=0, overrun=0.
REQ-031 After reset, lane i x = SCREEN_WIDTH - LANE_SPACING*i: 640, 480, 320, 160.

Verification
REQ-032 Reset, start, one frame_tick at level 0 -> update_done 5 cycles after tick; lane_x = 640,480,320,159.
REQ-033 4 ticks at level 0 from reset -> lane0 639, lane1 479, lane2 318, lane3 156.
REQ-034 Force lane3 to 33 via ticks, then 2 more ticks at level 3 -> 32, then 640 (wrap).
REQ-035 frame_tick 2 cycles after a prior tick -> dropped, overrun=1 and held, positions advance by one sweep only.
REQ-036 pause raised in SWEEP index 1 -> sweep completes, update_done pulses, state=3; ticks while paused -> no change; pause low -> WAIT next cycle.
REQ-037 reset asserted in SWEEP index 2 -> next cycle state=0, lane_x = 640,480,320,160, no update_done.

Source files
------------

// File: rtl/traffic_scheduler.sv
// traffic_scheduler: steps four lanes of scrolling cars once per video frame
// through a single shared decrement/wrap datapath, one lane per clock.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-high reset
//   start        level, leaves IDLE for WAIT
//   pause        level, freezes all lanes once the current sweep is done
//   frame_tick   one-cycle pulse per video frame, launches a sweep
//   level        difficulty 0..3, shortens each lane's move period
//   lane_x       packed car x positions, lane i at [10*i+9:10*i]
//   state        IDLE=0, WAIT=1, SWEEP=2, PAUSED=3
//   update_done  one-cycle pulse in the cycle after the last lane slot
//   overrun      sticky, a frame_tick landed while a sweep was running
module traffic_scheduler #(
    parameter int SCREEN_WIDTH = 640,
    parameter int CAR_WIDTH    = 32,
    parameter int LANE_SPACING = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        frame_tick,
    input  logic [1:0]  level,
    output logic [39:0] lane_x,
    output logic [1:0]  state,
    output logic        update_done,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SWEEP  = 2'd2,
        PAUSED = 2'd3
    } state_e;

    localparam logic [9:0] XMAX = 10'(SCREEN_WIDTH);
    localparam logic [9:0] XMIN = 10'(CAR_WIDTH);

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    logic [1:0]  cnt_q [4];
    logic [9:0]  x_q   [4];

    // Shared lane datapath, fed by the lane selected by idx_q.
    logic [9:0]  cur_x, nxt_x;
    logic [1:0]  cur_c, nxt_c;
    logic [2:0]  sum;
    logic [1:0]  pm1;
    logic        hit;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // pause wins over a coincident frame_tick
                if (pause) begin
                    state_d = PAUSED;
                end else if (frame_tick) begin
                    state_d = SWEEP;
                    idx_d   = 2'd0;
                end
            end
            SWEEP: begin
                if (frame_tick) begin
                    ovr_d = 1'b1;
                end
                // index wraps 3 -> 0, ready for the next sweep
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    done_d  = 1'b1;
                    state_d = pause ? PAUSED : WAIT;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lane datapath
    // ------------------------------------------------------------------
    always_comb begin
        cur_x = x_q[idx_q];
        cur_c = cnt_q[idx_q];
        // period = max(1, 4 - idx - level), so period-1 = max(0, 3 - sum)
        sum   = {1'b0, idx_q} + {1'b0, level};
        if (sum >= 3'd3) begin
            pm1 = 2'd0;
        end else begin
            pm1 = 2'(3'd3 - sum);
        end
        // >= lets a lowered period catch a counter that is already past it
        hit   = (cur_c >= pm1);
        nxt_c = hit ? 2'd0 : cur_c + 2'd1;
        nxt_x = cur_x;
        if (hit) begin
            nxt_x = (cur_x > XMIN) ? cur_x - 10'd1 : XMAX;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 2'd0;
                x_q[i]   <= 10'(SCREEN_WIDTH - LANE_SPACING * i);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            if (state_q == SWEEP) begin
                x_q[idx_q]   <= nxt_x;
                cnt_q[idx_q] <= nxt_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign lane_x[10*g +: 10] = x_q[g];
    end

    assign state       = state_q;
    assign update_done = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb_traffic_scheduler: directed scenarios plus random traffic, every cycle
// compared against a frame-level behavioural model of the scheduler.
module tb_traffic_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  level = 2'd0;
    logic [39:0] lane_x;
    logic [1:0]  state;
    logic        update_done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    traffic_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .frame_tick  (frame_tick),
        .level       (level),
        .lane_x      (lane_x),
        .state       (state),
        .update_done (update_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_mode;    // 0 idle, 1 wait, 2 sweep, 3 paused
    int m_slot;
    int m_x [4];
    int m_c [4];
    bit m_done;
    bit m_ovr;

    function automatic logic [39:0] m_pack();
        logic [39:0] v;
        for (int i = 0; i < 4; i++) v[10*i +: 10] = 10'(m_x[i]);
        return v;
    endfunction

    task automatic model_step();
        int per;
        m_done = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_slot = 0;
            m_ovr  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_x[i] = 640 - 160 * i;
                m_c[i] = 0;
            end
        end else begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: begin
                    if (pause) m_mode = 3;
                    else if (frame_tick) begin
                        m_mode = 2;
                        m_slot = 0;
                    end
                end
                2: begin
                    per = 4 - m_slot - int'(level);
                    if (per < 1) per = 1;
                    if (m_c[m_slot] >= per - 1) begin
                        m_c[m_slot] = 0;
                        if (m_x[m_slot] > 32) m_x[m_slot] -= 1;
                        else m_x[m_slot] = 640;
                    end else begin
                        m_c[m_slot] += 1;
                    end
                    if (frame_tick) m_ovr = 1'b1;
                    if (m_slot == 3) begin
                        m_done = 1'b1;
                        m_mode = pause ? 3 : 1;
                        m_slot = 0;
                    end else begin
                        m_slot += 1;
                    end
                end
                default: if (!pause) m_mode = 1;
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    // one clock: advance the model on the current inputs, then compare
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 64'(state), 64'(m_mode));
        chk("lane_x", 64'(lane_x), 64'(m_pack()));
        chk("update_done", 64'(update_done), 64'(m_done));
        chk("overrun", 64'(overrun), 64'(m_ovr));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        frame_tick = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    // full frame: tick then enough idle cycles for the sweep to finish
    task automatic frame();
        tick();
        idle_n(5);
    endtask

    logic [39:0] snap;
    int lat;

    initial begin
        do_reset();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_x", 64'(lane_x),
            64'({10'd160, 10'd320, 10'd480, 10'd640}));

        // start then one tick, measure latency to update_done
        go();
        chk("wait_state", 64'(state), 64'd1);
        tick();
        lat = 1;
        while (!update_done && lat < 20) begin
            cyc();
            lat++;
        end
        chk("done_latency", 64'(lat), 64'd5);
        chk("one_sweep_x", 64'(lane_x),
            64'({10'd159, 10'd320, 10'd480, 10'd640}));
        cyc();
        chk("done_one_cycle", 64'(update_done), 64'd0);

        // four frames from reset at level 0
        do_reset();
        go();
        for (int i = 0; i < 4; i++) frame();
        chk("four_frames_x", 64'(lane_x),
            64'({10'd156, 10'd318, 10'd479, 10'd639}));

        // drive lane3 down to 33, then wrap at level 3
        do_reset();
        go();
        for (int i = 0; i < 127; i++) frame();
        chk("lane3_33", 64'(lane_x[39:30]), 64'd33);
        level = 2'd3;
        frame();
        chk("lane3_32", 64'(lane_x[39:30]), 64'd32);
        frame();
        chk("lane3_wrap", 64'(lane_x[39:30]), 64'd640);
        level = 2'd0;

        // overlapping tick: dropped, overrun sticky
        do_reset();
        go();
        tick();
        cyc();
        tick();
        idle_n(4);
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overrun_x", 64'(lane_x),
            64'({10'd159, 10'd320, 10'd480, 10'd640}));
        idle_n(6);
        chk("overrun_held", 64'(overrun), 64'd1);

        // pause mid-sweep: sweep completes, then frozen
        do_reset();
        go();
        tick();
        cyc();
        pause = 1'b1;
        idle_n(3);
        chk("pause_done", 64'(update_done), 64'd1);
        chk("paused_state", 64'(state), 64'd3);
        snap = m_pack();
        for (int i = 0; i < 3; i++) tick();
        chk("paused_frozen", 64'(lane_x), 64'(snap));
        chk("paused_no_ovr", 64'(overrun), 64'd0);
        pause = 1'b0;
        cyc();
        chk("unpause_wait", 64'(state), 64'd1);

        // reset in sweep index 2
        tick();
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midsweep_rst_state", 64'(state), 64'd0);
        chk("midsweep_rst_x", 64'(lane_x),
            64'({10'd160, 10'd320, 10'd480, 10'd640}));
        chk("midsweep_rst_done", 64'(update_done), 64'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 9) == 0);
            frame_tick = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            if ($urandom_range(0, 39) == 0) level = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
